vga_capture: RTL and testbench

//  Receive side of the VGA pixel interface: samples a 16-bit RGB565 stream plus hsync/vsync from a

---
 rtl/vga_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture -- receive side of the VGA pixel interface.
//
// Registers the RGB565 stream and active-low syncs, tracks line/frame
// position, locks to the incoming timing and pushes active-window pixels
// into a 16-deep first-word-fall-through FIFO that drains over dout/dout_vld/rdy.
//
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   vga_rgb/hsync/vsync   pixel and active-low syncs from the timing source
//   dout, dout_vld, rdy   FIFO head; a transfer happens when dout_vld && rdy
//   locked                timing lock held
//   frame_sop             pulse when the first active pixel of a frame enters the FIFO
//   ovf                   sticky: a pixel was dropped in the current frame
//   frame_crc, crc_vld    CRC of the last complete clean frame plus update pulse
//
// Optional feature macro: VGA_CAPTURE_CRC_EN enables the per-frame
// CRC-16/CCITT. Without it frame_crc is 0 and crc_vld is 0.
module vga_capture #(
  parameter int H_TP    = 1650,
  parameter int H_START = 260,
  parameter int H_END   = 1540,
  parameter int V_TP    = 750,
  parameter int V_START = 25,
  parameter int V_END   = 745
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] vga_rgb,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic [15:0] dout,
  output logic        dout_vld,
  input  logic        rdy,
  output logic        locked,
  output logic        frame_sop,
  output logic        ovf,
  output logic [15:0] frame_crc,
  output logic        crc_vld
);

  typedef enum logic [1:0] {S_UNLOCK, S_ARMED, S_LOCKED} state_t;

  // S1 input registers plus previous S1 sync for edge detection
  logic [15:0] rgb_s1_q;
  logic        hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
  logic        hs_fall, vs_fall;

  logic [10:0] cnt_h_q, cnt_h_d;
  logic [9:0]  cnt_v_q, cnt_v_d;
  logic        chk_fail, active, first_px;
  state_t      state_q;
  logic        locked_q;

  logic        wr_vld_q, wr_sop_q;
  logic [15:0] wr_dat_q;

  logic [15:0] mem [16];
  logic [3:0]  wr_ptr_q, rd_ptr_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] last_q;
  logic        full, rd_en, push, drop;
  logic        ovf_q, sop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_s1_q <= '0;
      hs_s1_q  <= 1'b1;
      vs_s1_q  <= 1'b1;
      hs_s2_q  <= 1'b1;
      vs_s2_q  <= 1'b1;
    end else begin
      rgb_s1_q <= vga_rgb;
      hs_s1_q  <= vga_hsync;
      vs_s1_q  <= vga_vsync;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
    end
  end

  assign hs_fall = hs_s2_q & ~hs_s1_q;
  assign vs_fall = vs_s2_q & ~vs_s1_q;

  // cnt_*_d is the position of the sample currently in S1; the _q copy
  // holds the previous sample's position, which is what the length checks need.
  always_comb begin
    cnt_h_d = (cnt_h_q == 11'h7FF) ? cnt_h_q : cnt_h_q + 11'd1;
    if (hs_fall) cnt_h_d = '0;
    cnt_v_d = cnt_v_q;
    if (hs_fall) cnt_v_d = cnt_v_q + 10'd1;
    if (vs_fall) cnt_v_d = '0;   // frame start beats the line increment
  end

  assign chk_fail = (hs_fall && cnt_h_q != 11'(H_TP - 1)) ||
                    (vs_fall && cnt_v_q != 10'(V_TP - 1));

  assign active = locked_q &&
                  cnt_h_d >= 11'(H_START) && cnt_h_d < 11'(H_END) &&
                  cnt_v_d >= 10'(V_START) && cnt_v_d < 10'(V_END);
  assign first_px = cnt_h_d == 11'(H_START) && cnt_v_d == 10'(V_START);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Lock FSM; any failed length check in ARMED or LOCKED drops back to UNLOCK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_UNLOCK;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_UNLOCK: if (vs_fall) state_q <= S_ARMED;
        S_ARMED: begin
          if (chk_fail)     state_q <= S_UNLOCK;
          else if (vs_fall) begin
            state_q  <= S_LOCKED;
            locked_q <= 1'b1;
          end
        end
        S_LOCKED: if (chk_fail) begin
          state_q  <= S_UNLOCK;
          locked_q <= 1'b0;
        end
        default: begin
          state_q  <= S_UNLOCK;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Write stage: the full/drop decision is taken here so a same-cycle read
  // frees the slot for the incoming pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q <= 1'b0;
      wr_sop_q <= 1'b0;
      wr_dat_q <= '0;
    end else begin
      wr_vld_q <= active;
      wr_sop_q <= active && first_px;
      wr_dat_q <= rgb_s1_q;
    end
  end

  assign full  = cnt_q == 5'd16;
  assign rd_en = (cnt_q != 5'd0) && rdy;
  assign push  = wr_vld_q && (!full || rd_en);
  assign drop  = wr_vld_q && full && !rd_en;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, rd_en})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      sop_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 4'd1;
        last_q   <= mem[rd_ptr_q];
      end
      cnt_q <= cnt_d;
      if (drop)         ovf_q <= 1'b1;
      else if (vs_fall) ovf_q <= 1'b0;
      sop_q <= push && wr_sop_q;
    end
  end

  // Empty FIFO keeps presenting the last value read out.
  assign dout      = (cnt_q != 5'd0) ? mem[rd_ptr_q] : last_q;
  assign dout_vld  = cnt_q != 5'd0;
  assign locked    = locked_q;
  assign frame_sop = sop_q;
  assign ovf       = ovf_q;

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  logic [15:0] crc_q, fcrc_q, crc_fin;
  logic        any_q, cvld_q;

  // A push landing on the vsync-fall cycle still belongs to the ending frame.
  assign crc_fin = push ? crc_step(crc_q, wr_dat_q) : crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
      any_q  <= 1'b0;
      cvld_q <= 1'b0;
    end else begin
      cvld_q <= 1'b0;
      if (vs_fall) begin
        if ((any_q || push) && !ovf_q && !drop) begin
          fcrc_q <= crc_fin;
          cvld_q <= 1'b1;
        end
        crc_q <= 16'hFFFF;
        any_q <= 1'b0;
      end else if (push) begin
        crc_q <= crc_fin;
        any_q <= 1'b1;
      end
    end
  end

  assign frame_crc = fcrc_q;
  assign crc_vld   = cvld_q;
`else
  assign frame_crc = 16'h0000;
  assign crc_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture with a reduced frame geometry.
// The driver generates whole frames, and a frame-level model decides which
// pixels must reach the FIFO and queues them. A negedge monitor pops and
// compares on every transfer.
module tb_vga_capture;
  localparam int H_TP = 24, H_START = 6, H_END = 14, H_SW = 2;
  localparam int V_TP = 8,  V_START = 2, V_END = 6,  V_SW = 1;
`ifdef VGA_CAPTURE_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] vga_rgb = '0;
  logic        vga_hsync = 1'b1, vga_vsync = 1'b1, rdy = 1'b0;
  logic [15:0] dout, frame_crc;
  logic        dout_vld, locked, frame_sop, ovf, crc_vld;

  vga_capture #(.H_TP(H_TP), .H_START(H_START), .H_END(H_END),
                .V_TP(V_TP), .V_START(V_START), .V_END(V_END)) dut (
    .clk(clk), .rst(rst), .vga_rgb(vga_rgb), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .dout(dout), .dout_vld(dout_vld), .rdy(rdy),
    .locked(locked), .frame_sop(frame_sop), .ovf(ovf),
    .frame_crc(frame_crc), .crc_vld(crc_vld));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [15:0] expq[$];
  int sop_seen = 0, crc_seen = 0;

  // Frame-level model: 0 = unlocked, 1 = armed, 2 = locked
  int          mst = 0;
  logic [15:0] mcrc = 16'hFFFF, exp_crc = 16'h0000;
  int          mwrote = 0, exp_sop = 0, exp_crcp = 0, zrun = 0;
  bit          movf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wise CRC-16/CCITT-FALSE, pixel sent high byte first.
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [15:0] px);
    logic [7:0] b;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? px[15:8] : px[7:0];
      c = c ^ {b, 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_vld"}, dout_vld, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sop"}, frame_sop, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_frame_crc"}, frame_crc, 0);
    chk({tag, "_crc_vld"}, crc_vld, 0);
  endtask

  task automatic model_vs();
    if (CRC_ON && mwrote > 0 && !movf) begin
      exp_crc = mcrc;
      exp_crcp++;
    end
    mcrc = 16'hFFFF; mwrote = 0; movf = 1'b0;
    mst = (mst == 0) ? 1 : 2;
  endtask

  // mode: 0 random, 1 ramp (rgb = line position), 2 constant F800
  // rdy_mode: 0 random with short zero runs, 1 held low, 2 held high
  task automatic drive_frame(input int mode, input int bad_line, input int rst_line,
                             input int keep_max, input int rdy_mode);
    int kept = 0;
    bit rst_done = 1'b0;
    model_vs();
    for (int l = 0; l < V_TP; l++) begin
      int len = (l == bad_line) ? H_TP - 1 : H_TP;
      if (l > 0 && l - 1 == bad_line) mst = 0;   // short line seen at next hsync fall
      for (int h = 0; h < len; h++) begin
        bit rnow = (l == rst_line) && h >= H_START + 2 && h < H_START + 6;
        logic [15:0] px;
        tick();
        px = (mode == 1) ? 16'(h) : (mode == 2) ? 16'hF800 : 16'($urandom);
        vga_rgb   = px;
        vga_hsync = (h >= H_SW);
        vga_vsync = (l >= V_SW);
        rst       = rnow;
        if (rdy_mode == 1) rdy = 1'b0;
        else if (rdy_mode == 2) rdy = 1'b1;
        else if ($urandom_range(3) == 0 && zrun < 2) begin rdy = 1'b0; zrun++; end
        else begin rdy = 1'b1; zrun = 0; end
        if (rnow && !rst_done) begin
          rst_done = 1'b1;
          expq.delete();
          mst = 0; mcrc = 16'hFFFF; mwrote = 0; movf = 1'b0; exp_crc = 16'h0000;
        end
        if (l == rst_line && h == H_START + 6) chk_zero("midreset");
        if (h == 4) chk("locked", locked, (mst == 2) ? 1 : 0);
        if (l == 0 && h == 4) begin
          chk("crc_pulses", crc_seen, exp_crcp);
          chk("frame_crc", frame_crc, exp_crc);
          chk("ovf_cleared", ovf, 0);
        end
        if (!rnow && mst == 2 && h >= H_START && h < H_END && l >= V_START && l < V_END) begin
          if (kept < keep_max) begin
            expq.push_back(px);
            mcrc = crc_px(mcrc, px);
            mwrote++;
            kept++;
            if (h == H_START && l == V_START) exp_sop++;
          end else movf = 1'b1;
        end
      end
    end
    chk("ovf_frame_end", ovf, movf);
    chk("sop_count", sop_seen, exp_sop);
  endtask

  // Monitor: one comparison per accepted transfer
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_sop) sop_seen++;
        if (crc_vld) crc_seen++;
        if (dout_vld && rdy) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pixel_unexpected: got %0h want none at %0t", dout, $time);
          end else chk("pixel", dout, expq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cyc;
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    chk_zero("reset");
    repeat (3) tick();

    drive_frame(0, -1, -1, 999, 0);   // unlocked -> armed
    drive_frame(0, -1, -1, 999, 0);   // armed -> locked
    drive_frame(0, -1, -1, 999, 0);   // first captured frame
    drive_frame(0, -1,  3, 999, 0);   // reset held during active pixels
    drive_frame(1, -1, -1, 999, 0);
    drive_frame(1, -1, -1, 999, 0);
    drive_frame(1, -1, -1, 999, 0);   // ramp: first H_START, last H_END-1
    drive_frame(0,  3, -1, 999, 0);   // short line drops lock mid-frame
    drive_frame(0, -1, -1, 999, 0);   // clean frame -> relock at its end
    drive_frame(0, -1, -1, 16, 1);    // backpressure: 16 kept, rest dropped
    drive_frame(0, -1, -1, 999, 2);   // ovf cleared, backlog drains in order
    drive_frame(2, -1, -1, 999, 0);   // constant F800 for CRC
    drive_frame(0, -1, -1, 999, 0);
    drive_frame(0, -1, -1, 999, 0);

    vga_hsync = 1'b1; vga_vsync = 1'b1; rdy = 1'b1;
    wait_cyc = 0;
    while (expq.size() != 0 && wait_cyc < 300) begin
      tick();
      wait_cyc++;
    end
    repeat (3) tick();
    chk("queue_drained", expq.size(), 0);
    chk("final_dout_vld", dout_vld, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
